// File: rtl/mod5167_red_arbiter.sv
// Round-robin arbiter that shares one 3-stage mod-5167 centered-reduction pipeline
// between two burst requesters, with a credit-gated output FIFO so no result is lost.

module mod5167_red_arbiter #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [33:0] s0_data,
    input  logic        s0_last,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [33:0] s1_data,
    input  logic        s1_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_data,
    output logic        out_src,
    output logic        out_last,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t             state;
    state_t             stateNext;
    logic               rrLast;
    logic               rrLastNext;
    logic               creditOk;
    logic               accept0;
    logic               accept1;
    logic               accept;
    logic               redReset;
    logic signed [33:0] redIn;
    logic signed [33:0] stage1;
    logic signed [33:0] stage2;
    logic signed [33:0] centered;
    logic signed [12:0] redOut;
    logic [2:0]         tagVld;
    logic [2:0]         tagSrc;
    logic [2:0]         tagLast;
    logic [1:0]         inflightCnt;
    logic [AW:0]        fifoCnt;
    logic [AW-1:0]      wrPtr;
    logic [AW-1:0]      rdPtr;
    logic [12:0]        memData [DEPTH];
    logic               memSrc  [DEPTH];
    logic               memLast [DEPTH];
    logic               wrEn;
    logic               rdEn;

    // Credit counts only registered occupancy, so a pop frees its slot one cycle later.
    assign inflightCnt = 2'(tagVld[0]) + 2'(tagVld[1]) + 2'(tagVld[2]);
    assign creditOk    = (int'(inflightCnt) + int'(fifoCnt)) < DEPTH;

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state  <= IDLE;
            rrLast <= 1'b1;
        end else begin
            state  <= stateNext;
            rrLast <= rrLastNext;
        end
    end

    always_comb begin
        stateNext  = state;
        rrLastNext = rrLast;
        s0_ready   = 1'b0;
        s1_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (s0_valid && (!s1_valid || rrLast))
                    stateNext = GNT0;
                else if (s1_valid)
                    stateNext = GNT1;
            end
            GNT0: begin
                s0_ready = creditOk;
                if (s0_valid && creditOk && s0_last) begin
                    stateNext  = IDLE;
                    rrLastNext = 1'b0;
                end
            end
            GNT1: begin
                s1_ready = creditOk;
                if (s1_valid && creditOk && s1_last) begin
                    stateNext  = IDLE;
                    rrLastNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign accept0 = s0_valid && s0_ready;
    assign accept1 = s1_valid && s1_ready;
    assign accept  = accept0 || accept1;
    assign redIn   = accept0 ? s0_data : (accept1 ? s1_data : 34'd0);

    // Reducer: stage2 holds the truncating remainder in (-5167,5167); one
    // conditional add/subtract folds it into [-2583,2583].
    assign redReset = ~Reset_n;

    always_comb begin
        centered = stage2;
        if (stage2 > 34'sd2583)
            centered = stage2 - 34'sd5167;
        else if (stage2 < -34'sd2583)
            centered = stage2 + 34'sd5167;
    end

    always_ff @(posedge clk) begin
        if (redReset) begin
            stage1 <= '0;
            stage2 <= '0;
            redOut <= '0;
        end else begin
            stage1 <= redIn;
            stage2 <= stage1 % 34'sd5167;
            redOut <= centered[12:0];
        end
    end

    // Tag bit 2 lines up with redOut.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            tagVld  <= '0;
            tagSrc  <= '0;
            tagLast <= '0;
        end else begin
            tagVld  <= {tagVld[1:0], accept};
            tagSrc  <= {tagSrc[1:0], accept1};
            tagLast <= {tagLast[1:0], (accept0 && s0_last) || (accept1 && s1_last)};
        end
    end

    assign wrEn = tagVld[2];
    assign rdEn = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            fifoCnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                memData[i] <= '0;
                memSrc[i]  <= 1'b0;
                memLast[i] <= 1'b0;
            end
        end else begin
            if (wrEn) begin
                memData[wrPtr] <= redOut;
                memSrc[wrPtr]  <= tagSrc[2];
                memLast[wrPtr] <= tagLast[2];
                wrPtr <= (wrPtr == AW'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
            end
            if (rdEn)
                rdPtr <= (rdPtr == AW'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
            case ({wrEn, rdEn})
                2'b10:   fifoCnt <= fifoCnt + 1'b1;
                2'b01:   fifoCnt <= fifoCnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign out_valid = (fifoCnt != '0);
    assign out_data  = out_valid ? memData[rdPtr] : '0;
    assign out_src   = out_valid ? memSrc[rdPtr] : 1'b0;
    assign out_last  = out_valid ? memLast[rdPtr] : 1'b0;
    assign busy      = (state != IDLE) || (tagVld != '0) || out_valid;

endmodule

// File: tb/tb_mod5167_red_arbiter.sv
// Directed and randomized bench for mod5167_red_arbiter: arbitration order, latency,
// credit backpressure, throughput and centered mod-5167 results.

module tb_mod5167_red_arbiter;
    logic        clk = 1'b0;
    logic        Reset_n;
    logic        s0_valid;
    logic        s0_ready;
    logic [33:0] s0_data;
    logic        s0_last;
    logic        s1_valid;
    logic        s1_ready;
    logic [33:0] s1_data;
    logic        s1_last;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_data;
    logic        out_src;
    logic        out_last;
    logic        busy;

    typedef struct { logic [33:0] data; logic last; } word_t;
    typedef struct { logic [33:0] data; logic src; logic last; int cyc; } acc_t;
    typedef struct { logic [12:0] data; logic src; logic last; int cyc; } out_t;

    word_t q0[$];
    word_t q1[$];
    acc_t  accLog[$];
    out_t  outLog[$];
    bit    en0;
    bit    en1;
    bit    randReady;
    bit    readyVal;
    int    cycle;
    int    firstValid0 = -1;
    int    firstReady0 = -1;
    int    vectors;
    int    miscompares;

    mod5167_red_arbiter #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .Reset_n(Reset_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data), .s0_last(s0_last),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data), .s1_last(s1_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Input driver: presents queue heads shortly after each rising edge.
    initial begin
        s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
        s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            s0_valid  = en0 && (q0.size() > 0);
            s0_data   = (q0.size() > 0) ? q0[0].data : '0;
            s0_last   = (q0.size() > 0) ? q0[0].last : 1'b0;
            s1_valid  = en1 && (q1.size() > 0);
            s1_data   = (q1.size() > 0) ? q1[0].data : '0;
            s1_last   = (q1.size() > 0) ? q1[0].last : 1'b0;
            out_ready = randReady ? 1'($urandom_range(0, 1)) : readyVal;
        end
    end

    // Monitor: logs handshakes that will complete at the next rising edge.
    always @(negedge clk) begin
        if (Reset_n) begin
            if (s0_valid && firstValid0 < 0) firstValid0 = cycle;
            if (s0_ready && firstReady0 < 0) firstReady0 = cycle;
            if (s0_valid && s0_ready && q0.size() > 0) begin
                accLog.push_back('{q0[0].data, 1'b0, q0[0].last, cycle});
                q0.delete(0);
            end
            if (s1_valid && s1_ready && q1.size() > 0) begin
                accLog.push_back('{q1[0].data, 1'b1, q1[0].last, cycle});
                q1.delete(0);
            end
            if (out_valid && out_ready)
                outLog.push_back('{out_data, out_src, out_last, cycle});
        end
    end

    function automatic int centerMod(input logic [33:0] d);
        longint v;
        longint r;
        v = longint'($signed(d));
        r = v % 5167;
        if (r < 0) r += 5167;
        if (r > 2583) r -= 5167;
        return int'(r);
    endfunction

    task automatic doReset();
        @(negedge clk); #1;
        Reset_n = 1'b0; en0 = 0; en1 = 0; randReady = 0; readyVal = 0;
        q0.delete(); q1.delete();
        repeat (3) @(negedge clk);
        #1;
        Reset_n = 1'b1;
        accLog.delete(); outLog.delete();
        firstValid0 = -1; firstReady0 = -1;
    endtask

    task automatic waitOutputs(input int n, input int budget);
        for (int i = 0; i < budget && outLog.size() < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({s0_ready, s1_ready, out_valid, out_data, out_src, out_last, busy} !== 19'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b, want 0", {s0_ready, s1_ready, out_valid, out_data, out_src, out_last, busy});
        end
        Reset_n = 1'b1;
        for (int i = 0; i < 6; i++) q0.push_back('{34'(100 + i), i == 5});
        en0 = 1;
        for (int i = 0; i < 30 && accLog.size() < 2; i++) begin
            @(negedge clk); #1;
        end
        vectors++;
        if (accLog.size() < 2) begin
            miscompares++;
            $display("[TB] FAIL reset_setup_accepts: got %0d, want >=2", accLog.size());
        end
        @(negedge clk); #1;
        Reset_n = 1'b0; en0 = 0;
        @(posedge clk); #1;
        vectors++;
        if ({s0_ready, s1_ready, out_valid, busy} !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_midburst: got %b, want 0000", {s0_ready, s1_ready, out_valid, busy});
        end
        q0.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        Reset_n = 1'b1; readyVal = 1; accLog.delete(); outLog.delete();
        repeat (15) @(negedge clk);
        #1;
        vectors++;
        if (outLog.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_stale_output: got %0d outputs, want 0", outLog.size());
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_single_burst();
        logic [33:0] din[4];
        int expData[4];
        int got;
        int lat;
        din[0] = 34'd0; din[1] = 34'd5168; din[2] = 34'd2584; din[3] = -34'sd2584;
        expData[0] = 0; expData[1] = 1; expData[2] = -2583; expData[3] = 2583;
        doReset();
        readyVal = 1;
        for (int i = 0; i < 4; i++) q0.push_back('{din[i], i == 3});
        en0 = 1;
        waitOutputs(4, 40);
        vectors++;
        if (outLog.size() != 4) begin
            miscompares++;
            $display("[TB] FAIL burst_count: got %0d, want 4", outLog.size());
        end
        for (int i = 0; i < 4 && i < outLog.size(); i++) begin
            got = int'($signed(outLog[i].data));
            vectors += 3;
            if (got != expData[i]) begin
                miscompares++;
                $display("[TB] FAIL burst_data[%0d]: got %0d, want %0d", i, got, expData[i]);
            end
            if (outLog[i].src !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL burst_src[%0d]: got %b, want 0", i, outLog[i].src);
            end
            if (outLog[i].last !== (i == 3)) begin
                miscompares++;
                $display("[TB] FAIL burst_last[%0d]: got %b, want %b", i, outLog[i].last, i == 3);
            end
        end
        vectors++;
        if (firstReady0 - firstValid0 != 1) begin
            miscompares++;
            $display("[TB] FAIL grant_bubble: got %0d cycles, want 1", firstReady0 - firstValid0);
        end
        lat = (outLog.size() > 0 && accLog.size() > 0) ? outLog[0].cyc - accLog[0].cyc : -1;
        vectors++;
        if (lat != 4) begin
            miscompares++;
            $display("[TB] FAIL latency: got %0d, want 4", lat);
        end
    endtask

    task automatic test_contention();
        int expData[8];
        logic expSrc[8];
        int got;
        expData = '{10, 11, 20, 21, 12, 13, 22, 23};
        expSrc  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        doReset();
        readyVal = 1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{34'(10 + i), i[0]});
            q1.push_back('{34'(20 + i), i[0]});
        end
        en0 = 1; en1 = 1;
        waitOutputs(8, 80);
        vectors++;
        if (outLog.size() != 8) begin
            miscompares++;
            $display("[TB] FAIL contention_count: got %0d, want 8", outLog.size());
        end
        for (int i = 0; i < 8 && i < outLog.size(); i++) begin
            got = int'($signed(outLog[i].data));
            vectors += 3;
            if (got != expData[i]) begin
                miscompares++;
                $display("[TB] FAIL contention_data[%0d]: got %0d, want %0d", i, got, expData[i]);
            end
            if (outLog[i].src !== expSrc[i]) begin
                miscompares++;
                $display("[TB] FAIL contention_src[%0d]: got %b, want %b", i, outLog[i].src, expSrc[i]);
            end
            if (outLog[i].last !== 1'(i % 2)) begin
                miscompares++;
                $display("[TB] FAIL contention_last[%0d]: got %b, want %b", i, outLog[i].last, 1'(i % 2));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] sent[20];
        int got;
        doReset();
        readyVal = 0;
        for (int i = 0; i < 20; i++) begin
            sent[i] = 34'(i * 987654 - 5000000);
            q0.push_back('{sent[i], i == 19});
        end
        en0 = 1;
        repeat (30) @(negedge clk);
        #1;
        vectors++;
        if (accLog.size() != 8) begin
            miscompares++;
            $display("[TB] FAIL bp_accepts: got %0d, want 8", accLog.size());
        end
        vectors++;
        if (s0_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_ready: got %b, want 0", s0_ready);
        end
        readyVal = 1;
        waitOutputs(20, 150);
        repeat (5) @(negedge clk);
        #1;
        vectors++;
        if (outLog.size() != 20) begin
            miscompares++;
            $display("[TB] FAIL bp_drain_count: got %0d, want 20", outLog.size());
        end
        for (int i = 0; i < 20 && i < outLog.size(); i++) begin
            got = int'($signed(outLog[i].data));
            vectors += 2;
            if (got != centerMod(sent[i])) begin
                miscompares++;
                $display("[TB] FAIL bp_data[%0d]: got %0d, want %0d", i, got, centerMod(sent[i]));
            end
            if (outLog[i].last !== (i == 19)) begin
                miscompares++;
                $display("[TB] FAIL bp_last[%0d]: got %b, want %b", i, outLog[i].last, i == 19);
            end
        end
    endtask

    task automatic test_throughput();
        logic [33:0] sent[64];
        int got;
        int span;
        doReset();
        readyVal = 1;
        for (int i = 0; i < 64; i++) begin
            sent[i] = 34'(i * 77777 + 12345);
            q0.push_back('{sent[i], i == 63});
        end
        en0 = 1;
        waitOutputs(64, 150);
        vectors++;
        if (outLog.size() != 64 || accLog.size() != 64) begin
            miscompares++;
            $display("[TB] FAIL tp_count: got %0d/%0d, want 64/64", accLog.size(), outLog.size());
        end else begin
            span = accLog[63].cyc - accLog[0].cyc;
            vectors++;
            if (span != 63) begin
                miscompares++;
                $display("[TB] FAIL tp_accept_span: got %0d, want 63", span);
            end
            span = outLog[63].cyc - outLog[0].cyc;
            vectors++;
            if (span != 63) begin
                miscompares++;
                $display("[TB] FAIL tp_output_span: got %0d, want 63", span);
            end
            for (int i = 0; i < 64; i++) begin
                got = int'($signed(outLog[i].data));
                vectors++;
                if (got != centerMod(sent[i])) begin
                    miscompares++;
                    $display("[TB] FAIL tp_data[%0d]: got %0d, want %0d", i, got, centerMod(sent[i]));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [33:0] specials[8];
        logic [33:0] v;
        logic [1:0]  hi;
        bit          src;
        int          len;
        int          si;
        int          total;
        int          got;
        int          want;
        specials[0] = 34'h2_0000_0000;  specials[1] = 34'h1_FFFF_FFFF;
        specials[2] = 34'sd5167;        specials[3] = -34'sd5167;
        specials[4] = 34'sd2583;        specials[5] = -34'sd2583;
        specials[6] = 34'sd2584;        specials[7] = -34'sd2584;
        doReset();
        total = 0;
        for (int i = 0; i < 8; i++) begin
            q0.push_back('{specials[i], i == 7});
            q1.push_back('{specials[7 - i], i == 7});
            total += 2;
        end
        while (total < 3000) begin
            src = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    si = $urandom_range(0, 7);
                    v = specials[si];
                end else begin
                    hi = 2'($urandom_range(0, 3));
                    v = {hi, $urandom()};
                end
                if (src) q1.push_back('{v, k == len - 1});
                else     q0.push_back('{v, k == len - 1});
                total++;
            end
        end
        randReady = 1;
        en0 = 1; en1 = 1;
        waitOutputs(total, 40000);
        randReady = 0; readyVal = 1;
        repeat (10) @(negedge clk);
        #1;
        vectors++;
        if (outLog.size() != total || accLog.size() != total) begin
            miscompares++;
            $display("[TB] FAIL rand_count: got %0d/%0d, want %0d", accLog.size(), outLog.size(), total);
        end
        for (int i = 0; i < outLog.size() && i < accLog.size(); i++) begin
            got  = int'($signed(outLog[i].data));
            want = centerMod(accLog[i].data);
            vectors += 3;
            if (got != want) begin
                miscompares++;
                $display("[TB] FAIL rand_data[%0d]: got %0d, want %0d (in %h)", i, got, want, accLog[i].data);
            end
            if (outLog[i].src !== accLog[i].src) begin
                miscompares++;
                $display("[TB] FAIL rand_src[%0d]: got %b, want %b", i, outLog[i].src, accLog[i].src);
            end
            if (outLog[i].last !== accLog[i].last) begin
                miscompares++;
                $display("[TB] FAIL rand_last[%0d]: got %b, want %b", i, outLog[i].last, accLog[i].last);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rand_idle_busy: got %b, want 0", busy);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        Reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        test_single_burst();
        test_contention();
        test_backpressure();
        test_throughput();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
